// File: rtl/pll_lock_sequencer.sv
// Power-up / recovery sequencer for the clk_wiz_0 PLL: pulses the PLL reset, qualifies lock,
// and holds the system reset until lock has been stable, retrying on timeout.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 10000,
  parameter int unsigned STABLE_CYCLES = 64,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic       CLK_in_100MHz,
  input  logic       reset,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_reset,
  output logic       rst_sys,
  output logic       ready,
  output logic       lock_fail,
  output logic       lock_lost,
  output logic [3:0] retry_count,
  output logic [2:0] state
);

  localparam int unsigned MaxAB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MaxP  = (MaxAB > STABLE_CYCLES) ? MaxAB : STABLE_CYCLES;
  localparam int unsigned CntW  = (MaxP > 1) ? $clog2(MaxP) : 1;

  localparam logic [CntW-1:0] RstLast     = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 1);
  localparam logic [3:0]      MaxRetry    = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StRst    = 3'd0,
    StWait   = 3'd1,
    StStable = 3'd2,
    StRun    = 3'd3,
    StFail   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      retry_q, retry_d;
  logic            lost_q, lost_d;
  logic            pll_reset_q, pll_reset_d;
  logic            rst_sys_q, rst_sys_d;
  logic            ready_q, ready_d;
  logic            lock_fail_q, lock_fail_d;
  logic            locked_meta, locked_s;

  // Two-flop synchroniser for the asynchronous wizard lock output.
  always_ff @(posedge CLK_in_100MHz or posedge reset) begin
    if (reset) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      locked_meta <= locked;
      locked_s    <= locked_meta;
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    if (restart) begin
      state_d = StRst;
      retry_d = '0;
      lost_d  = 1'b0;
    end else begin
      case (state_q)
        StRst: begin
          if (cnt_q == RstLast) state_d = StWait;
        end
        StWait: begin
          // A lock seen on the timeout cycle still wins.
          if (locked_s) begin
            state_d = StStable;
          end else if (cnt_q == TimeoutLast) begin
            if (retry_q == MaxRetry) begin
              state_d = StFail;
            end else begin
              retry_d = retry_q + 4'd1;
              state_d = StRst;
            end
          end
        end
        StStable: begin
          if (!locked_s) begin
            state_d = StWait;
          end else if (cnt_q == StableLast) begin
            state_d = StRun;
            retry_d = '0;
          end
        end
        StRun: begin
          if (!locked_s) begin
            lost_d  = 1'b1;
            state_d = StRst;
          end
        end
        StFail:  state_d = StFail;
        default: state_d = StRst;
      endcase
    end
  end

  // Shared phase counter: restarts on any state change, idles where no timing is needed.
  always_comb begin
    cnt_d = cnt_q;
    if (restart || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == StRst) || (state_q == StWait) || (state_q == StStable)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs are decoded from the next state so they move on the same edge as state.
  always_comb begin
    pll_reset_d = 1'b1;
    rst_sys_d   = 1'b1;
    ready_d     = 1'b0;
    lock_fail_d = 1'b0;
    case (state_d)
      StWait, StStable: pll_reset_d = 1'b0;
      StRun: begin
        pll_reset_d = 1'b0;
        rst_sys_d   = 1'b0;
        ready_d     = 1'b1;
      end
      StFail:  lock_fail_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK_in_100MHz or posedge reset) begin
    if (reset) begin
      state_q     <= StRst;
      cnt_q       <= '0;
      retry_q     <= '0;
      lost_q      <= 1'b0;
      pll_reset_q <= 1'b1;
      rst_sys_q   <= 1'b1;
      ready_q     <= 1'b0;
      lock_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      pll_reset_q <= pll_reset_d;
      rst_sys_q   <= rst_sys_d;
      ready_q     <= ready_d;
      lock_fail_q <= lock_fail_d;
    end
  end

  assign pll_reset   = pll_reset_q;
  assign rst_sys     = rst_sys_q;
  assign ready       = ready_q;
  assign lock_fail   = lock_fail_q;
  assign lock_lost   = lost_q;
  assign retry_count = retry_q;
  assign state       = state_q;

endmodule
